// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg
// Shared definitions for the WS2812B chain controller: register word
// addresses, CONTROL/STATUS/IRQ bit positions and masks, the DEV_ID value,
// the frame sequencer state encoding and a byte-lane merge helper.
package ws2812b_pkg;

  localparam logic [31:0] DEV_ID_VALUE = 32'hECE4_5310;

  // Word addresses
  localparam int unsigned ADDR_DEV_ID     = 0;
  localparam int unsigned ADDR_CONTROL    = 1;
  localparam int unsigned ADDR_STATUS     = 2;
  localparam int unsigned ADDR_IM         = 3;
  localparam int unsigned ADDR_IRQ        = 4;
  localparam int unsigned ADDR_LENGTH     = 5;
  localparam int unsigned ADDR_PIXEL_BASE = 8;

  // CONTROL bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_AUTO_BIT  = 1;

  // STATUS bits
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_IDX_LSB  = 8;

  // IRQ / IM bits
  localparam int unsigned IRQ_DONE_BIT = 0;
  localparam int unsigned IRQ_REJ_BIT  = 1;
  localparam logic [1:0]  IRQ_DONE_MASK = 2'b01;
  localparam logic [1:0]  IRQ_REJ_MASK  = 2'b10;

  // Frame sequencer states (fixed encoding kept from the legacy design)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  // Replace the byte lanes of old_v selected by be with those of new_v.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// ws2812b_bit_timer
// Generates the waveform of one WS2812B bit: the line is high for T1H_CYC
// (bit=1) or T0H_CYC (bit=0) cycles, then low until TBIT_CYC cycles have
// elapsed. A go pulse in the same cycle as o_done starts the next bit with
// no gap, so consecutive bits are exactly TBIT_CYC apart.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_go            start a bit (line rises on this edge)
//   i_bit           value of the bit being started, sampled with i_go
//   o_line          serial line level
//   o_high_end      last cycle of the high phase
//   o_done          last cycle of the bit period
module ws2812b_bit_timer #(
  parameter int unsigned T0H_CYC  = 20,
  parameter int unsigned T1H_CYC  = 40,
  parameter int unsigned TBIT_CYC = 63,
  parameter int unsigned CNT_W    = 12
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_go,
  input  logic i_bit,
  output logic o_line,
  output logic o_high_end,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_bit;
  logic             r_line;
  logic [CNT_W-1:0] w_th_last;

  assign w_th_last  = r_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign o_high_end = r_active && r_line && (r_cnt == w_th_last);
  assign o_done     = r_active && (r_cnt == CNT_W'(TBIT_CYC - 1));
  assign o_line     = r_line;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_line   <= 1'b0;
    end else if (i_go) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_bit    <= i_bit;
      r_line   <= 1'b1;
    end else if (r_active) begin
      if (o_done) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (o_high_end) r_line <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812b_chain_ctrl.sv
// ws2812b_chain_ctrl
// Avalon-MM slave register file with shadow pixel storage and a WS2812B
// serializer for one data line. A frame sends a snapshot of LENGTH pixels
// (G,R,B, MSB first) taken at start, followed by a low latch period.
// Optional feature macro: WS2812B_AUTO_REFRESH_EN (CONTROL.AUTO restarts
// frames back to back while set).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   slave_address/read/write   Avalon-MM word address and strobes
//   slave_writedata/byteenable write data and byte lanes
//   slave_readdata             combinational read data
//   data_out                   WS2812B serial line
//   busy                       frame in progress, including latch period
//   irq_out                    |(IM & IRQ)
module ws2812b_chain_ctrl
  import ws2812b_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned T0H_CYC    = 20,
  parameter int unsigned T1H_CYC    = 40,
  parameter int unsigned TBIT_CYC   = 63,
  parameter int unsigned TRST_CYC   = 2750
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  output logic [31:0]       slave_readdata,
  input  logic [31:0]       slave_writedata,
  input  logic [3:0]        slave_byteenable,
  output logic              data_out,
  output logic              busy,
  output logic              irq_out
);

  localparam int unsigned CNT_MAX = (TRST_CYC > TBIT_CYC) ? TRST_CYC : TBIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LEN_W   = $clog2(NUM_PIXELS + 1);
  localparam int unsigned IDX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  // Register file
  logic [23:0]      r_pix_shadow [NUM_PIXELS];
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_im;
  logic [1:0]       r_irq;
  logic             r_start_pend;
  logic             w_auto;

  // Frame engine
  state_t           r_state;
  logic [23:0]      r_pix_act [NUM_PIXELS];
  logic [LEN_W-1:0] r_len_act;
  logic [IDX_W-1:0] r_idx;
  logic [4:0]       r_bitn;
  logic [CNT_W-1:0] r_lcnt;
  logic             r_busy;

  // Decode
  logic [31:0]      w_addr32;
  logic [31:0]      w_pix_off;
  logic             w_pix_sel;
  logic [IDX_W-1:0] w_pix_idx;
  logic [31:0]      w_pix_merged;
  logic [31:0]      w_len_merged;
  logic [LEN_W-1:0] w_len_next;
  logic             w_wr_ctrl, w_wr_im, w_wr_irq, w_wr_len, w_wr_pix;
  logic             w_start_req, w_start_ok, w_start_rej;
  logic [1:0]       w_irq_clr, w_irq_set;
  logic             w_done_set;

  // Bit sequencing
  logic             w_go, w_go_bit, w_last, w_high_end, w_done, w_line;
  logic [IDX_W-1:0] w_idx_nx;

  assign w_addr32  = 32'(slave_address);
  assign w_pix_off = w_addr32 - 32'(ADDR_PIXEL_BASE);
  assign w_pix_sel = (w_addr32 >= 32'(ADDR_PIXEL_BASE)) && (w_pix_off < 32'(NUM_PIXELS));
  assign w_pix_idx = w_pix_sel ? w_pix_off[IDX_W-1:0] : '0;

  assign w_wr_ctrl = slave_write && (w_addr32 == 32'(ADDR_CONTROL));
  assign w_wr_im   = slave_write && (w_addr32 == 32'(ADDR_IM));
  assign w_wr_irq  = slave_write && (w_addr32 == 32'(ADDR_IRQ));
  assign w_wr_len  = slave_write && (w_addr32 == 32'(ADDR_LENGTH));
  assign w_wr_pix  = slave_write && w_pix_sel;

  assign w_pix_merged = be_merge({8'h00, r_pix_shadow[w_pix_idx]}, slave_writedata, slave_byteenable);
  assign w_len_merged = be_merge(32'(r_len), slave_writedata, slave_byteenable);
  assign w_len_next   = (w_len_merged > 32'(NUM_PIXELS)) ? LEN_W'(NUM_PIXELS)
                                                         : w_len_merged[LEN_W-1:0];

  // Acceptance uses the registered busy, so a START landing on the edge where
  // busy falls is still rejected; a pending START also blocks a second one.
  assign w_start_req = w_wr_ctrl && slave_byteenable[0] && slave_writedata[CTRL_START_BIT];
  assign w_start_ok  = w_start_req && !r_busy && !r_start_pend && (r_len != '0);
  assign w_start_rej = w_start_req && !w_start_ok;

  assign w_done_set = (r_state == ST_LATCH) && (r_lcnt == CNT_W'(TRST_CYC - 1));
  assign w_irq_set  = (w_start_rej ? IRQ_REJ_MASK : 2'b00) | (w_done_set ? IRQ_DONE_MASK : 2'b00);
  assign w_irq_clr  = (w_wr_irq && slave_byteenable[0]) ? slave_writedata[1:0] : 2'b00;

`ifdef WS2812B_AUTO_REFRESH_EN
  logic r_auto;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto <= 1'b0;
    end else if (w_wr_ctrl && slave_byteenable[0]) begin
      r_auto <= slave_writedata[CTRL_AUTO_BIT];
    end
  end
  assign w_auto = r_auto;
`else
  assign w_auto = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len <= LEN_W'(NUM_PIXELS);
      r_im  <= '0;
      r_irq <= '0;
      for (int unsigned i = 0; i < NUM_PIXELS; i++) r_pix_shadow[i] <= '0;
    end else begin
      if (w_wr_len) r_len <= w_len_next;
      if (w_wr_im && slave_byteenable[0]) r_im <= slave_writedata[1:0];
      if (w_wr_pix) r_pix_shadow[w_pix_idx] <= w_pix_merged[23:0];
      // Set has priority over a same-cycle write-1-to-clear.
      r_irq <= (r_irq & ~w_irq_clr) | w_irq_set;
    end
  end

  assign w_last   = (r_bitn == 5'd0) && ((32'(r_idx) + 32'd1) == 32'(r_len_act));
  assign w_idx_nx = (32'(r_idx) == NUM_PIXELS - 1) ? r_idx : r_idx + 1'b1;

  // LOAD issues the first bit straight from the shadow copy because the
  // active snapshot is only written on that same edge.
  always_comb begin
    w_go     = 1'b0;
    w_go_bit = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_go     = 1'b1;
        w_go_bit = r_pix_shadow[0][23];
      end
      ST_LOW: begin
        if (w_done && !w_last) begin
          w_go = 1'b1;
          if (r_bitn == 5'd0) w_go_bit = r_pix_act[w_idx_nx][23];
          else                w_go_bit = r_pix_act[r_idx][r_bitn - 5'd1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_start_pend <= 1'b0;
      r_len_act    <= '0;
      r_idx        <= '0;
      r_bitn       <= '0;
      r_lcnt       <= '0;
      for (int unsigned i = 0; i < NUM_PIXELS; i++) r_pix_act[i] <= '0;
    end else begin
      if (w_start_ok) r_start_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_start_pend) begin
            r_start_pend <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_pix_act <= r_pix_shadow;
          r_len_act <= r_len;
          r_idx     <= '0;
          r_bitn    <= 5'd23;
          r_state   <= ST_HIGH;
        end
        ST_HIGH: begin
          if (w_high_end) r_state <= ST_LOW;
        end
        ST_LOW: begin
          if (w_done) begin
            if (w_last) begin
              r_lcnt  <= '0;
              r_state <= ST_LATCH;
            end else begin
              r_state <= ST_HIGH;
              if (r_bitn == 5'd0) begin
                r_bitn <= 5'd23;
                r_idx  <= w_idx_nx;
              end else begin
                r_bitn <= r_bitn - 5'd1;
              end
            end
          end
        end
        ST_LATCH: begin
          if (w_done_set) begin
            if (w_auto && (r_len != '0)) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ws2812b_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC),
    .CNT_W   (CNT_W)
  ) u_bit_timer (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_go      (w_go),
    .i_bit     (w_go_bit),
    .o_line    (w_line),
    .o_high_end(w_high_end),
    .o_done    (w_done)
  );

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      if (w_pix_sel) begin
        slave_readdata = {8'h00, r_pix_shadow[w_pix_idx]};
      end else begin
        case (w_addr32)
          32'(ADDR_DEV_ID):  slave_readdata = DEV_ID_VALUE;
          32'(ADDR_CONTROL): slave_readdata = {30'd0, w_auto, 1'b0};
          32'(ADDR_STATUS):  slave_readdata = {16'd0, 8'(r_idx), 7'd0, r_busy};
          32'(ADDR_IM):      slave_readdata = {30'd0, r_im};
          32'(ADDR_IRQ):     slave_readdata = {30'd0, r_irq};
          32'(ADDR_LENGTH):  slave_readdata = 32'(r_len);
          default:           slave_readdata = '0;
        endcase
      end
    end
  end

  assign data_out = w_line;
  assign busy     = r_busy;
  assign irq_out  = |(r_im & r_irq);

endmodule

// File: tb/tb_ws2812b_chain_ctrl.sv
// tb_ws2812b_chain_ctrl
// Directed self-checking bench for ws2812b_chain_ctrl with small timing
// parameters (T0H=2, T1H=4, TBIT=6, TRST=20, 4 pixels). Define
// WS2812B_AUTO_REFRESH_EN for both bench and RTL to exercise auto-refresh.
module tb_ws2812b_chain_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_readdata;
  logic [31:0] slave_writedata;
  logic [3:0]  slave_byteenable;
  logic        data_out;
  logic        busy;
  logic        irq_out;

  int n_cmp;
  int n_bad;

  logic cap_b [400];
  logic cap_d [400];
  logic exp_b [400];
  logic exp_d [400];

  ws2812b_chain_ctrl #(
    .NUM_PIXELS(4),
    .ADDR_W    (4),
    .T0H_CYC   (2),
    .T1H_CYC   (4),
    .TBIT_CYC  (6),
    .TRST_CYC  (20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .slave_address   (slave_address),
    .slave_read      (slave_read),
    .slave_write     (slave_write),
    .slave_readdata  (slave_readdata),
    .slave_writedata (slave_writedata),
    .slave_byteenable(slave_byteenable),
    .data_out        (data_out),
    .busy            (busy),
    .irq_out         (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    slave_address    = a;
    slave_writedata  = d;
    slave_byteenable = be;
    slave_write      = 1'b1;
    @(posedge clk);
    #1;
    slave_write      = 1'b0;
    slave_byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    #1;
    d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 400; k++) begin
      exp_b[k] = 1'b0;
      exp_d[k] = 1'b0;
    end
  endtask

  // Expected line waveform of one pixel whose first bit starts at sample base.
  task automatic model_pixel(input int base, input logic [23:0] pix);
    for (int b = 0; b < 24; b++) begin
      int th;
      th = pix[23 - b] ? 4 : 2;
      for (int c = 0; c < 6; c++) exp_d[base + b*6 + c] = (c < th);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (data_out !== 1'b0) begin n_bad++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
    n_cmp++; if (irq_out !== 1'b0)  begin n_bad++; $display("FAIL reset_irq_out: got %b expected 0", irq_out); end
    bus_read(4'd0, rd);
    n_cmp++; if (rd !== 32'hECE45310) begin n_bad++; $display("FAIL reset_dev_id: got %h expected ece45310", rd); end
    bus_read(4'd5, rd);
    n_cmp++; if (rd !== 32'd4) begin n_bad++; $display("FAIL reset_length: got %h expected 00000004", rd); end
    bus_read(4'd1, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_control: got %h expected 00000000", rd); end
    bus_read(4'd6, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reserved_read: got %h expected 00000000", rd); end
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    int nb, bad_d, bad_b;
    bus_write(4'd8, 32'h0080_0001, 4'hF);
    bus_write(4'd5, 32'd1, 4'hF);
    bus_write(4'd1, 32'd1, 4'hF);
    for (int k = 0; k < 180; k++) begin
      @(negedge clk);
      cap_b[k] = busy;
      cap_d[k] = data_out;
    end
    clear_exp();
    for (int k = 1; k <= 165; k++) exp_b[k] = 1'b1;
    model_pixel(2, 24'h800001);
    nb = 0; bad_d = -1; bad_b = -1;
    for (int k = 0; k < 180; k++) begin
      if (cap_b[k] === 1'b1) nb++;
      if (cap_d[k] !== exp_d[k] && bad_d < 0) bad_d = k;
      if (cap_b[k] !== exp_b[k] && bad_b < 0) bad_b = k;
    end
    n_cmp++; if (nb !== 165) begin n_bad++; $display("FAIL frame1_busy_len: got %0d expected 165", nb); end
    n_cmp++; if (bad_b >= 0) begin n_bad++; $display("FAIL frame1_busy_wave: sample %0d got %b expected %b", bad_b, cap_b[bad_b], exp_b[bad_b]); end
    n_cmp++; if (bad_d >= 0) begin n_bad++; $display("FAIL frame1_data_wave: sample %0d got %b expected %b", bad_d, cap_d[bad_d], exp_d[bad_d]); end
    bus_read(4'd4, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL frame1_irq: got %h expected 00000001", rd); end
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL frame1_irq_masked: got %b expected 0", irq_out); end
  endtask

  task automatic test_byteenable();
    logic [31:0] rd;
    bus_write(4'd9, 32'hFFFF_FFFF, 4'b0010);
    bus_read(4'd9, rd);
    n_cmp++; if (rd !== 32'h0000_FF00) begin n_bad++; $display("FAIL be_lane1: got %h expected 0000ff00", rd); end
    bus_write(4'd9, 32'h0000_0012, 4'b0001);
    bus_read(4'd9, rd);
    n_cmp++; if (rd !== 32'h0000_FF12) begin n_bad++; $display("FAIL be_lane0: got %h expected 0000ff12", rd); end
    bus_write(4'd10, 32'hAABB_CCDD, 4'hF);
    bus_read(4'd10, rd);
    n_cmp++; if (rd !== 32'h00BB_CCDD) begin n_bad++; $display("FAIL pixel_top_byte: got %h expected 00bbccdd", rd); end
  endtask

  task automatic test_reject_during_frame();
    logic [31:0] rd, st;
    int nb, bad_b;
    bus_write(4'd4, 32'h3, 4'hF);
    bus_write(4'd5, 32'd2, 4'hF);
    bus_write(4'd1, 32'd1, 4'hF);
    st = '0;
    for (int k = 0; k < 340; k++) begin
      @(negedge clk);
      cap_b[k] = busy;
      slave_write = 1'b0;
      if (k == 40 || k == 309) begin
        slave_address = 4'd1; slave_writedata = 32'd1; slave_byteenable = 4'hF; slave_write = 1'b1;
      end
      if (k == 150) begin
        slave_address = 4'd2; slave_read = 1'b1;
        #1 st = slave_readdata;
        slave_read = 1'b0;
      end
    end
    clear_exp();
    for (int k = 1; k <= 309; k++) exp_b[k] = 1'b1;
    nb = 0; bad_b = -1;
    for (int k = 0; k < 340; k++) begin
      if (cap_b[k] === 1'b1) nb++;
      if (cap_b[k] !== exp_b[k] && bad_b < 0) bad_b = k;
    end
    n_cmp++; if (st !== 32'h0000_0101) begin n_bad++; $display("FAIL status_mid_frame: got %h expected 00000101", st); end
    n_cmp++; if (nb !== 309) begin n_bad++; $display("FAIL frame2_busy_len: got %0d expected 309", nb); end
    n_cmp++; if (bad_b >= 0) begin n_bad++; $display("FAIL frame2_busy_wave: sample %0d got %b expected %b", bad_b, cap_b[bad_b], exp_b[bad_b]); end
    bus_read(4'd4, rd);
    n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL reject_irq: got %h expected 00000003", rd); end
    bus_write(4'd4, 32'h2, 4'hF);
    bus_read(4'd4, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL w1c_reject: got %h expected 00000001", rd); end
    bus_write(4'd3, 32'h1, 4'hF);
    @(negedge clk);
    n_cmp++; if (irq_out !== 1'b1) begin n_bad++; $display("FAIL irq_out_done: got %b expected 1", irq_out); end
    bus_write(4'd4, 32'h1, 4'hF);
    @(negedge clk);
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_out_cleared: got %b expected 0", irq_out); end
  endtask

  task automatic test_length();
    logic [31:0] rd;
    int nb;
    bus_write(4'd5, 32'd9, 4'hF);
    bus_read(4'd5, rd);
    n_cmp++; if (rd !== 32'd4) begin n_bad++; $display("FAIL length_clamp: got %h expected 00000004", rd); end
    bus_write(4'd5, 32'd0, 4'hF);
    bus_write(4'd1, 32'd1, 4'hF);
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL len0_busy: got %0d busy cycles expected 0", nb); end
    bus_read(4'd4, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL len0_reject_irq: got %h expected 00000002", rd); end
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_out_reject_masked: got %b expected 0", irq_out); end
    bus_write(4'd4, 32'h3, 4'hF);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    bus_write(4'd5, 32'd4, 4'hF);
    bus_write(4'd1, 32'd1, 4'hF);
    repeat (30) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (data_out !== 1'b0) begin n_bad++; $display("FAIL abort_data_out: got %b expected 0", data_out); end
    bus_read(4'd9, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL abort_pixel_cleared: got %h expected 00000000", rd); end
    bus_read(4'd3, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL abort_im_cleared: got %h expected 00000000", rd); end
  endtask

`ifdef WS2812B_AUTO_REFRESH_EN
  task automatic test_auto();
    logic [31:0] rd;
    int nb, bad_b, bad_d;
    bus_write(4'd8, 32'h0, 4'hF);
    bus_write(4'd5, 32'd1, 4'hF);
    bus_write(4'd1, 32'h3, 4'hF);
    for (int k = 0; k < 360; k++) begin
      @(negedge clk);
      cap_b[k] = busy;
      cap_d[k] = data_out;
      slave_write = 1'b0;
      if (k == 50) begin
        slave_address = 4'd8; slave_writedata = 32'h00FF_FFFF; slave_byteenable = 4'hF; slave_write = 1'b1;
      end
      if (k == 200) begin
        slave_address = 4'd1; slave_writedata = 32'h0; slave_byteenable = 4'hF; slave_write = 1'b1;
      end
    end
    clear_exp();
    for (int k = 1; k <= 330; k++) exp_b[k] = 1'b1;
    model_pixel(2, 24'h000000);
    model_pixel(167, 24'hFFFFFF);
    nb = 0; bad_b = -1; bad_d = -1;
    for (int k = 0; k < 360; k++) begin
      if (cap_b[k] === 1'b1) nb++;
      if (cap_b[k] !== exp_b[k] && bad_b < 0) bad_b = k;
      if (cap_d[k] !== exp_d[k] && bad_d < 0) bad_d = k;
    end
    n_cmp++; if (nb !== 330) begin n_bad++; $display("FAIL auto_busy_len: got %0d expected 330", nb); end
    n_cmp++; if (bad_b >= 0) begin n_bad++; $display("FAIL auto_busy_wave: sample %0d got %b expected %b", bad_b, cap_b[bad_b], exp_b[bad_b]); end
    n_cmp++; if (bad_d >= 0) begin n_bad++; $display("FAIL auto_data_wave: sample %0d got %b expected %b", bad_d, cap_d[bad_d], exp_d[bad_d]); end
    bus_read(4'd4, rd);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL auto_irq: got %h expected 00000001", rd); end
  endtask
`else
  task automatic test_auto();
    logic [31:0] rd;
    int nb;
    bus_write(4'd1, 32'h2, 4'hF);
    bus_read(4'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL auto_disabled_read: got %h expected 00000000", rd); end
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL auto_disabled_busy: got %0d busy cycles expected 0", nb); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset            = 1'b1;
    slave_address    = 4'h0;
    slave_read       = 1'b0;
    slave_write      = 1'b0;
    slave_writedata  = 32'h0;
    slave_byteenable = 4'h0;
    test_reset();
    test_frame();
    test_byteenable();
    test_reject_during_frame();
    test_length();
    test_reset_midframe();
    test_auto();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
